// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble, stall data refresh and EX/MEM, MEM/WB operand forwarding
//   clk, rst                     : clock, asynchronous active-high reset
//   id_*                         : decoded instruction fields from ID
//   stall, flush                 : hold stage / kill stage
//   exm_*, mwb_*                 : writeback ports of EX/MEM and MEM/WB used as forwarding sources
//   ex_*, alu_a, alu_b, load_use : registered EX fields, forwarded ALU operands, ID hold request
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_aluop,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_asel_pc,
  input  logic              id_bsel_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              stall,
  input  logic              flush,
  input  logic              exm_regwrite,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_regwrite,
  input  logic [RA_W-1:0]   mwb_rd,
  input  logic [DATA_W-1:0] mwb_wdata,
  output logic              ex_valid,
  output logic [4:0]        ex_aluop,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use
);
  typedef struct packed {
    logic              valid;
    logic [4:0]        aluop;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic              asel_pc;
    logic              bsel_imm;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } ex_t;
  ex_t q, d, id_pkt, hold;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  // x0 is never a forwarding source; EX/MEM is younger so it wins over MEM/WB
  always_comb begin
    fwd_a = (exm_regwrite && |exm_rd && exm_rd == q.rs1) ? exm_result :
            (mwb_regwrite && |mwb_rd && mwb_rd == q.rs1) ? mwb_wdata : q.rs1_data;
    fwd_b = (exm_regwrite && |exm_rd && exm_rd == q.rs2) ? exm_result :
            (mwb_regwrite && |mwb_rd && mwb_rd == q.rs2) ? mwb_wdata : q.rs2_data;
  end
  assign load_use = q.valid && q.memread && id_valid && |q.rd && (q.rd == id_rs1 || q.rd == id_rs2);
  always_comb begin
    id_pkt = '{valid: id_valid, aluop: id_aluop, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
               rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm, pc: id_pc,
               asel_pc: id_asel_pc, bsel_imm: id_bsel_imm, regwrite: id_regwrite,
               memread: id_memread, memwrite: id_memwrite};
    // a stalled stage captures forwarded operands so a writeback retiring mid-stall is kept
    hold = q;
    hold.rs1_data = fwd_a;
    hold.rs2_data = fwd_b;
    d = (flush || load_use) ? '0 : stall ? hold : id_valid ? id_pkt : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= d;
  assign ex_valid = q.valid;
  assign ex_aluop = q.aluop;
  assign ex_rd = q.rd;
  assign ex_regwrite = q.regwrite;
  assign ex_memread = q.memread;
  assign ex_memwrite = q.memwrite;
  assign alu_a = q.asel_pc ? q.pc : fwd_a;
  assign alu_b = q.bsel_imm ? q.imm : fwd_b;
  assign ex_store_data = fwd_b;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL take parameters: DATA_W, 32, datapath width; RA_W, 5, register-address width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-003 The block SHALL have these ID-side inputs: id_valid 1, id_aluop 5, id_rs1 5, id_rs2 5, id_rd 5, id_rs1_data 32, id_rs2_data 32, id_imm 32, id_pc 32, id_asel_pc 1 (A=PC), id_bsel_imm 1 (B=imm), id_regwrite 1, id_memread 1, id_memwrite 1.
REQ-004 The block SHALL have these control inputs: stall 1 (hold stage), flush 1 (kill stage).
REQ-005 The block SHALL have these forwarding inputs: exm_regwrite 1, exm_rd 5, exm_result 32 (EX/MEM); mwb_regwrite 1, mwb_rd 5, mwb_wdata 32 (MEM/WB).
REQ-006 The block SHALL have these outputs to the ALU and the next stage: ex_valid 1, ex_aluop 5, alu_a 32, alu_b 32, ex_rd 5, ex_regwrite 1, ex_memread 1, ex_memwrite 1, ex_store_data 32, load_use 1 (ID must hold).

Function
REQ-007 The block SHALL register all ID fields on each rising clk edge, giving EX exactly 1 cycle of latency.
REQ-008 Per-edge update priority SHALL be: flush > load_use bubble > stall > normal load.
REQ-009 Flush SHALL load a bubble: ex_valid=0, ex_aluop=5'b00000 (nop), ex_regwrite=0, ex_memread=0, ex_memwrite=0; data fields are don't-care but zeroed.
REQ-010 load_use SHALL be combinational: ex_valid & ex_memread & id_valid & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-011 When load_use=1 and flush=0, the stage SHALL load a bubble (REQ-009); upstream holds the ID contents, so the instruction re-presents in the next cycle.
REQ-012 When stall=1 (and no flush/load_use), all control fields SHALL hold; the stored rs1/rs2 data SHALL be refreshed with their forwarded values (REQ-013) so that a writeback retiring during the stall is not lost.
REQ-013 Forwarded rs1 SHALL be: exm_result if exm_regwrite & exm_rd!=0 & exm_rd==ex_rs1; else mwb_wdata if mwb_regwrite & mwb_rd!=0 & mwb_rd==ex_rs1; else the stored rs1 data. rs2 SHALL be handled identically; EX/MEM SHALL win over MEM/WB.
REQ-014 alu_a SHALL be ex_pc when ex_asel_pc=1, else forwarded rs1; alu_b SHALL be ex_imm when ex_bsel_imm=1, else forwarded rs2 (lui/auipc pass imm on B).
REQ-015 ex_store_data SHALL always equal forwarded rs2, independent of ex_bsel_imm.
REQ-016 alu_a, alu_b and ex_store_data SHALL be combinational from registered state and the forwarding inputs, and SHALL add no extra cycle.
REQ-017 When id_valid=0 at a normal load, the stage SHALL load a bubble.
REQ-018 Register x0 SHALL never be a forwarding source or a hazard source (rd==0 ignored).
REQ-019 ex_aluop SHALL carry id_aluop unchanged (5-bit encoding: nop 00000, lui 00001, auipc 00010, add 00011, sub 00100, sll 01000, srl 01100, sra 11000); no decoding is performed here.

Reset
REQ-020 rst=1 SHALL asynchronously force a bubble (REQ-009) and clear all data fields to 0, giving alu_a=alu_b=0 absent forwarding.
REQ-021 Deassertion of rst SHALL take effect at the next rising clk edge; the first valid ID instruction SHALL appear at EX one edge later.
REQ-022 Reset asserted mid-stall or mid-hazard SHALL override both; no held state SHALL survive.

Verification
REQ-023 Reset: drive rst=1 mid-cycle -> ex_valid=0, ex_aluop=00000, ex_regwrite=0 immediately, before the next edge.
REQ-024 EX/MEM forward: EX holds add x3,x1,x2 with stored x1=5, x2=7; exm_regwrite=1, exm_rd=1, exm_result=100 -> alu_a=100, alu_b=7; mwb_rd=1, mwb_wdata=9 simultaneously -> alu_a still 100.
REQ-025 Load-use: EX holds a load with rd=4; ID presents sub with rs2=4 -> load_use=1; next edge -> ex_valid=0, ex_aluop=00000; next edge (ID held) -> sub enters EX.
REQ-026 Stall refresh: EX holds rs1=6 with stored data 0; stall=1 while mwb_regwrite=1, mwb_rd=6, mwb_wdata=0x55 for one cycle; then release -> alu_a=0x55 after MEM/WB moves on.
REQ-027 Flush vs stall: flush=1 and stall=1 on the same edge -> bubble loaded (ex_valid=0).
REQ-028 x0/imm select: exm_rd=0, exm_regwrite=1, exm_result=0xFFFF with ex_rs1=0 -> no forward; ex_bsel_imm=1, imm=0x12345000, aluop=00001 -> alu_b=0x12345000.
